// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// systolic_skew_feeder: holds 5x5 A/B operands, streams them as skewed waves
// Revision: 1.0
// ============================================================================
module systolic_skew_feeder #(
    parameter int N   = 32,
    parameter int DIM = 5
) (
    input  logic         clk,
    input  logic         init,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic         start,
    output logic         busy,
    output logic         out_valid,
    output logic         done,
    output logic [N-1:0] A0,
    output logic [N-1:0] A1,
    output logic [N-1:0] A2,
    output logic [N-1:0] A3,
    output logic [N-1:0] A4,
    output logic [N-1:0] B0,
    output logic [N-1:0] B1,
    output logic [N-1:0] B2,
    output logic [N-1:0] B3,
    output logic [N-1:0] B4
);

    localparam int         WORDS     = DIM * DIM;
    localparam logic [3:0] LAST_BEAT = 4'(2 * DIM - 2);

    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t       state, state_next;
    logic [3:0]   beat, beat_next;
    logic [N-1:0] mem_a [WORDS];
    logic [N-1:0] mem_b [WORDS];
    logic [N-1:0] a_beat [DIM];
    logic [N-1:0] b_beat [DIM];
    logic [N-1:0] a_reg [DIM];
    logic [N-1:0] b_reg [DIM];
    logic         valid_reg, done_reg;

    assign busy = (state == STREAM);

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en && !busy && (wr_addr < 5'(WORDS))) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // The last beat may hand straight over to a new stream so beats run gapless.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    beat_next  = '0;
                end
            end
            STREAM: begin
                if (beat == LAST_BEAT) begin
                    beat_next = '0;
                    if (!start) state_next = IDLE;
                end else begin
                    beat_next = beat + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            a_beat[k] = '0;
            b_beat[k] = '0;
            if ((beat >= 4'(k)) && (beat <= 4'(k + DIM - 1))) begin
                a_beat[k] = mem_a[5'(k * DIM) + 5'(beat) - 5'(k)];
                b_beat[k] = mem_b[(5'(beat) - 5'(k)) * 5'(DIM) + 5'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init || state != STREAM) begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            for (int k = 0; k < DIM; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
            end
        end else begin
            valid_reg <= 1'b1;
            done_reg  <= (beat == LAST_BEAT);
            for (int k = 0; k < DIM; k++) begin
                a_reg[k] <= a_beat[k];
                b_reg[k] <= b_beat[k];
            end
        end
    end

    assign out_valid = valid_reg;
    assign done      = done_reg;
    assign A0 = a_reg[0];
    assign A1 = a_reg[1];
    assign A2 = a_reg[2];
    assign A3 = a_reg[3];
    assign A4 = a_reg[4];
    assign B0 = b_reg[0];
    assign B1 = b_reg[1];
    assign B2 = b_reg[2];
    assign B3 = b_reg[3];
    assign B4 = b_reg[4];

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// tb_systolic_skew_feeder: self-checking bench with a beat-schedule model
// Revision: 1.0
// ============================================================================
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        busy, out_valid, done;
    logic [31:0] A0, A1, A2, A3, A4, B0, B1, B2, B3, B4;

    int tests = 0;
    int fails = 0;

    systolic_skew_feeder #(.N(32), .DIM(5)) dut (
        .clk(clk), .init(init), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .busy(busy), .out_valid(out_valid), .done(done),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stream started at edge `base` registers beat t at edge base+t+1.
    logic [31:0] ma [25];
    logic [31:0] mb [25];
    logic [31:0] ea [5];
    logic [31:0] eb [5];
    logic        e_valid = 1'b0, e_done = 1'b0, e_busy = 1'b0;
    int          n = 0;
    int          base = -100;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        int t;
        bit busy_pre;
        n++;
        armed = 1'b1;
        if (init) begin
            for (int i = 0; i < 25; i++) begin ma[i] = 0; mb[i] = 0; end
            for (int k = 0; k < 5; k++) begin ea[k] = 0; eb[k] = 0; end
            e_valid = 0; e_done = 0;
            base = -100;
        end else begin
            t = n - base - 1;
            busy_pre = (t >= 0) && (t <= 8);
            e_valid = busy_pre;
            e_done  = (t == 8);
            for (int k = 0; k < 5; k++) begin
                ea[k] = 0; eb[k] = 0;
                if (busy_pre && (t - k >= 0) && (t - k <= 4)) begin
                    ea[k] = ma[k * 5 + (t - k)];
                    eb[k] = mb[(t - k) * 5 + k];
                end
            end
            if (!busy_pre && wr_en && wr_addr < 25) begin
                if (wr_sel) mb[wr_addr] = wr_data;
                else        ma[wr_addr] = wr_data;
            end
            if (start && !(t >= 0 && t <= 7)) base = n;
        end
        e_busy = (n - base >= 0) && (n - base <= 8);
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("done", 32'(done), 32'(e_done));
            check("A0", A0, ea[0]); check("A1", A1, ea[1]); check("A2", A2, ea[2]);
            check("A3", A3, ea[3]); check("A4", A4, ea[4]);
            check("B0", B0, eb[0]); check("B1", B1, eb[1]); check("B2", B2, eb[2]);
            check("B3", B3, eb[3]); check("B4", B4, eb[4]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input logic [4:0] addr, input logic [31:0] data);
        wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick;
        wr_en = 0;
    endtask

    task automatic run_stream(input int extra);
        start = 1; tick; start = 0;
        for (int i = 0; i < 9 + extra; i++) tick;
    endtask

    function automatic logic [31:0] all_or();
        return A0 | A1 | A2 | A3 | A4 | B0 | B1 | B2 | B3 | B4;
    endfunction

    initial begin
        int cnt, v, d;
        // Reset held with start and a write pending.
        init = 1; start = 1; wr_en = 1; wr_addr = 0; wr_data = 32'h55;
        tick; check("rst_outs", all_or(), 0); check("rst_valid", 32'(out_valid), 0);
        tick; check("rst_busy", 32'(busy), 0); check("rst_done", 32'(done), 0);
        init = 0; start = 0; wr_en = 0;
        tick;
        start = 1; tick; start = 0;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (done) begin cnt = k; break; end
        end
        check("done_latency", 32'(cnt), 32'd9);
        tick; tick;

        // Skew pattern.
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                write(1'b0, 5'(i * 5 + j), 32'(5 * i + j + 1));
                write(1'b1, 5'(i * 5 + j), (i == j) ? 32'd1 : 32'd0);
            end
        start = 1; tick; start = 0;
        tick;
        check("b0_A0", A0, 1); check("b0_B0", B0, 1);
        check("b0_rest", A1 | A2 | A3 | A4 | B1 | B2 | B3 | B4, 0);
        for (int i = 0; i < 4; i++) tick;
        check("b4_A0", A0, 5); check("b4_A1", A1, 9); check("b4_A2", A2, 13);
        check("b4_A3", A3, 17); check("b4_A4", A4, 21);
        check("b4_B2", B2, 1); check("b4_Brest", B0 | B1 | B3 | B4, 0);
        for (int i = 0; i < 4; i++) tick;
        check("b8_A4", A4, 25); check("b8_B4", B4, 1); check("b8_done", 32'(done), 1);
        check("b8_rest", A0 | A1 | A2 | A3 | B0 | B1 | B2 | B3, 0);
        tick; tick;

        // Busy protection: write and start during beat 3.
        start = 1; tick; start = 0;
        for (int i = 0; i < 4; i++) tick;
        wr_en = 1; wr_sel = 0; wr_addr = 5'd4; wr_data = 32'hDEAD; start = 1;
        tick;
        wr_en = 0; start = 0;
        check("busy_A0", A0, 5);
        d = (done) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin tick; if (done) d++; end
        check("busy_done_count", 32'(d), 1);

        // Address bound.
        write(1'b0, 5'd25, 32'hFFFF_FFFF);
        write(1'b1, 5'd31, 32'hFFFF_FFFF);
        write(1'b0, 5'd31, 32'hFFFF_FFFF);
        write(1'b1, 5'd25, 32'hFFFF_FFFF);
        run_stream(2);

        // Back-to-back: second start sampled on the edge registering beat 8.
        start = 1; tick; start = 0;
        v = 0; d = 0;
        for (int i = 1; i <= 18; i++) begin
            if (i == 9) start = 1;
            tick;
            start = 0;
            if (out_valid) v++;
            if (done) d++;
        end
        check("b2b_valid", 32'(v), 18);
        check("b2b_done", 32'(d), 2);
        tick; tick;

        // Same-edge write and start.
        wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 32'd7; start = 1;
        tick;
        wr_en = 0; start = 0;
        tick;
        check("same_edge_A0", A0, 7);
        for (int i = 0; i < 10; i++) tick;

        // Reset mid-stream during beat 5.
        start = 1; tick; start = 0;
        for (int i = 0; i < 6; i++) tick;
        init = 1; tick; init = 0;
        check("mid_valid", 32'(out_valid), 0); check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0); check("mid_outs", all_or(), 0);
        start = 1; tick; start = 0;
        tick;
        check("post_rst_A0", A0, 0);
        for (int i = 0; i < 10; i++) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
